// File: rtl/tile_axil_ctrl_master.sv
// tile_axil_ctrl_master: AXI4-Lite initiator turning single register commands into transactions, with a stall watchdog
module tile_axil_ctrl_master #(
  parameter int BW       = 32,
  parameter int BWB      = BW / 8,
  parameter int AXI_ADDR = 8,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk_control,
  input  logic                clk_control_rst_high,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [AXI_ADDR-1:0] cmd_addr,
  input  logic [BW-1:0]       cmd_wdata,
  input  logic [BWB-1:0]      cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [BW-1:0]       rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic [AXI_ADDR-1:0] control_M_AXI_AWADDR,
  output logic                control_M_AXI_AWVALID,
  input  logic                control_M_AXI_AWREADY,
  output logic [BW-1:0]       control_M_AXI_WDATA,
  output logic [BWB-1:0]      control_M_AXI_WSTRB,
  output logic                control_M_AXI_WVALID,
  input  logic                control_M_AXI_WREADY,
  input  logic [1:0]          control_M_AXI_BRESP,
  input  logic                control_M_AXI_BVALID,
  output logic                control_M_AXI_BREADY,
  output logic [AXI_ADDR-1:0] control_M_AXI_ARADDR,
  output logic                control_M_AXI_ARVALID,
  input  logic                control_M_AXI_ARREADY,
  input  logic [BW-1:0]       control_M_AXI_RDATA,
  input  logic [1:0]          control_M_AXI_RRESP,
  input  logic                control_M_AXI_RVALID,
  output logic                control_M_AXI_RREADY,
  output logic                busy,
  output logic                timeout_err
);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD, RD_DATA, RSP} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  state_t state, state_n;
  logic [AXI_ADDR-1:0] addr_q;
  logic [CW-1:0] wd_cnt, wd_n;
  logic accept, waiting, aw_done, w_done;
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cmd_valid && state == IDLE;
  assign control_M_AXI_AWADDR = addr_q;
  assign control_M_AXI_ARADDR = addr_q;
  assign aw_done = !control_M_AXI_AWVALID || control_M_AXI_AWREADY;
  assign w_done = !control_M_AXI_WVALID || control_M_AXI_WREADY;
  assign waiting = state == WR || state == WR_RESP || state == RD || state == RD_DATA;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = cmd_valid ? (cmd_write ? WR : RD) : IDLE;
      WR:      state_n = aw_done && w_done ? WR_RESP : WR;
      WR_RESP: state_n = control_M_AXI_BVALID ? RSP : WR_RESP;
      RD:      state_n = control_M_AXI_ARREADY ? RD_DATA : RD;
      RD_DATA: state_n = control_M_AXI_RVALID ? RSP : RD_DATA;
      RSP:     state_n = rsp_ready ? IDLE : RSP;
      default: state_n = IDLE;
    endcase
    // counter restarts whenever the transaction leaves the slave-wait states
    wd_n = (state_n == RSP || state_n == IDLE) ? '0 :
           (TIMEOUT != 0 && waiting && wd_cnt != TMAX) ? wd_cnt + 1'b1 : wd_cnt;
  end
  always_ff @(posedge clk_control) begin
    if (clk_control_rst_high) begin
      state <= IDLE;
      addr_q <= '0;
      control_M_AXI_WDATA <= '0;
      control_M_AXI_WSTRB <= '0;
      control_M_AXI_AWVALID <= 1'b0;
      control_M_AXI_WVALID <= 1'b0;
      control_M_AXI_BREADY <= 1'b0;
      control_M_AXI_ARVALID <= 1'b0;
      control_M_AXI_RREADY <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp <= '0;
      wd_cnt <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q <= cmd_addr;
        control_M_AXI_WDATA <= cmd_wdata;
        control_M_AXI_WSTRB <= cmd_wstrb;
      end
      control_M_AXI_AWVALID <= (accept && cmd_write) || (control_M_AXI_AWVALID && !control_M_AXI_AWREADY);
      control_M_AXI_WVALID <= (accept && cmd_write) || (control_M_AXI_WVALID && !control_M_AXI_WREADY);
      control_M_AXI_ARVALID <= (accept && !cmd_write) || (control_M_AXI_ARVALID && !control_M_AXI_ARREADY);
      control_M_AXI_BREADY <= state_n == WR_RESP;
      control_M_AXI_RREADY <= state_n == RD_DATA;
      rsp_valid <= state_n == RSP;
      if (state == WR_RESP && control_M_AXI_BVALID) begin
        rsp_write <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp <= control_M_AXI_BRESP;
      end
      if (state == RD_DATA && control_M_AXI_RVALID) begin
        rsp_write <= 1'b0;
        rsp_rdata <= control_M_AXI_RDATA;
        rsp_resp <= control_M_AXI_RRESP;
      end
      wd_cnt <= wd_n;
      timeout_err <= timeout_err || (TIMEOUT != 0 && wd_n == TMAX);
    end
  end
endmodule

// File: tb/tb_tile_axil_ctrl_master.sv
// tb_tile_axil_ctrl_master: directed bench with a response scoreboard and a hand-driven AXI-Lite slave
module tb_tile_axil_ctrl_master;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0] cmd_wstrb = 0;
  logic rsp_valid, rsp_ready = 0, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [7:0] awaddr, araddr;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic [31:0] wdata, rdata = 0;
  logic [3:0] wstrb;
  logic [1:0] bresp = 0, rresp = 0;
  logic arvalid, arready = 0, rvalid = 0, rready, busy, timeout_err;
  int n_cmp = 0, n_err = 0;
  typedef struct {logic w; logic [31:0] d; logic [1:0] r;} rsp_t;
  rsp_t sb[$];
  rsp_t exp_r;

  tile_axil_ctrl_master #(.TIMEOUT(16)) dut (
    .clk_control(clk), .clk_control_rst_high(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .control_M_AXI_AWADDR(awaddr), .control_M_AXI_AWVALID(awvalid), .control_M_AXI_AWREADY(awready),
    .control_M_AXI_WDATA(wdata), .control_M_AXI_WSTRB(wstrb), .control_M_AXI_WVALID(wvalid),
    .control_M_AXI_WREADY(wready), .control_M_AXI_BRESP(bresp), .control_M_AXI_BVALID(bvalid),
    .control_M_AXI_BREADY(bready), .control_M_AXI_ARADDR(araddr), .control_M_AXI_ARVALID(arvalid),
    .control_M_AXI_ARREADY(arready), .control_M_AXI_RDATA(rdata), .control_M_AXI_RRESP(rresp),
    .control_M_AXI_RVALID(rvalid), .control_M_AXI_RREADY(rready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench hung");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] ed, input logic [1:0] er);
    chk("cmd_ready_before_issue", cmd_ready, 1);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    sb.push_back('{w, ed, er});
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(input string tag, input int budget);
    int k;
    k = 0;
    while (!rsp_valid && k < budget) begin tick(); k++; end
    chk({tag, "_rsp_seen"}, rsp_valid, 1);
    if (rsp_valid && sb.size() > 0) begin
      exp_r = sb.pop_front();
      chk({tag, "_rsp_write"}, rsp_write, exp_r.w);
      chk({tag, "_rsp_rdata"}, rsp_rdata, exp_r.d);
      chk({tag, "_rsp_resp"}, rsp_resp, exp_r.r);
    end
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk({tag, "_rsp_dropped"}, rsp_valid, 0);
  endtask

  initial begin
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
    chk("rst_timeout", timeout_err, 0);

    // zero-wait write
    awready = 1; wready = 1;
    issue(1, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'd0);
    chk("w0_aw_w_valid_c1", {awvalid, wvalid, bready}, 3'b110);
    chk("w0_awaddr", awaddr, 8'h10);
    chk("w0_wdata", {wstrb, wdata}, {4'hF, 32'hDEADBEEF});
    chk("w0_busy", {busy, cmd_ready}, 2'b10);
    bvalid = 1; bresp = 0;
    tick();
    chk("w0_bready_c2", {awvalid, wvalid, bready}, 3'b001);
    tick();
    bvalid = 0;
    chk("w0_rsp_valid_c3", {rsp_valid, bready}, 2'b10);
    wait_rsp("w0", 4);
    ack_rsp("w0");
    chk("w0_idle", cmd_ready, 1);

    // skewed write: W handshakes three cycles before AW
    awready = 0; wready = 1;
    issue(1, 8'h24, 32'h0BADF00D, 4'h5, 32'h0, 2'd1);
    chk("sk_c1", {awvalid, wvalid}, 2'b11);
    tick();
    wready = 0;
    for (int i = 0; i < 3; i++) begin
      chk("sk_w_dropped", {awvalid, wvalid, bready}, 3'b100);
      chk("sk_stable", {awaddr, wstrb, wdata}, {8'h24, 4'h5, 32'h0BADF00D});
      if (i == 2) awready = 1;
      tick();
    end
    awready = 0;
    chk("sk_bready", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1; bresp = 1;
    tick();
    bvalid = 0;
    chk("sk_single_b", {bready, wvalid}, 2'b00);
    wait_rsp("sk", 4);
    ack_rsp("sk");

    // read with ARREADY after two cycles, SLVERR response
    issue(0, 8'h04, 32'h0, 4'h0, 32'h12345678, 2'd2);
    chk("rd_arvalid", {arvalid, awvalid, wvalid}, 3'b100);
    chk("rd_araddr", araddr, 8'h04);
    tick(); tick();
    chk("rd_ar_hold", {arvalid, rready}, 2'b10);
    arready = 1;
    tick();
    arready = 0;
    chk("rd_rready", {arvalid, rready}, 2'b01);
    rvalid = 1; rdata = 32'h12345678; rresp = 2;
    tick();
    rvalid = 0;
    chk("rd_rready_drop", rready, 0);
    wait_rsp("rd", 4);
    ack_rsp("rd");

    // back-pressure with the next command already waiting
    awready = 1; wready = 1; bvalid = 1; bresp = 3;
    issue(1, 8'h20, 32'hA5A5A5A5, 4'hC, 32'h0, 2'd3);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h08;
    wait_rsp("bp", 6);
    bvalid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_stable", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, 1'b1, 32'h0, 2'd3});
      chk("bp_cmd_blocked", {cmd_ready, busy}, 2'b01);
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("bp_next_ready", {cmd_ready, rsp_valid}, 2'b10);
    sb.push_back('{1'b0, 32'hCAFEF00D, 2'd0});
    arready = 1; rvalid = 1; rdata = 32'hCAFEF00D; rresp = 0;
    tick();
    cmd_valid = 0;
    chk("bp_next_accepted", {arvalid, cmd_ready}, 2'b10);
    chk("bp_next_addr", araddr, 8'h08);
    wait_rsp("bp2", 4);
    ack_rsp("bp2");
    arready = 0; rvalid = 0;

    // watchdog: slave withholds BVALID
    awready = 1; wready = 1; bvalid = 0;
    issue(1, 8'h30, 32'h11112222, 4'hF, 32'h0, 2'd2);
    for (int i = 0; i < 15; i++) tick();
    chk("wd_not_yet", timeout_err, 0);
    tick();
    chk("wd_set", {timeout_err, busy}, 2'b11);
    for (int i = 0; i < 5; i++) tick();
    chk("wd_sticky_waiting", {timeout_err, busy, bready}, 3'b111);
    bvalid = 1; bresp = 2;
    tick();
    bvalid = 0;
    wait_rsp("wd", 4);
    ack_rsp("wd");
    chk("wd_sticky_after", timeout_err, 1);

    // reset while in RD_DATA
    arready = 1;
    issue(0, 8'h0C, 32'h0, 4'h0, 32'h0, 2'd0);
    tick();
    arready = 0;
    chk("rst_mid_rd_data", {arvalid, rready, busy}, 3'b011);
    rst = 1;
    tick();
    rst = 0;
    void'(sb.pop_back());
    chk("rst_mid_outputs", {arvalid, rready, rsp_valid, busy}, 4'b0000);
    chk("rst_mid_ready_err", {cmd_ready, timeout_err}, 2'b10);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tile_axil_ctrl_master.md
Name: tile_axil_ctrl_master

Overview:
- AXI4-Lite initiator that drives a tile's control_S_AXI_* slave port from a simple command/response stream.
- Sits in the control-clock domain between the host/NoC configuration logic and one tile's control port.
- Converts single register read/write commands into AXI-Lite transactions and returns the data and response.
- One transaction in flight at a time. Includes a watchdog that flags a stalled slave.

Parameters:
- BW, 32, AXI data width.
- BWB, BW/8, write-strobe width.
- AXI_ADDR, 8, AXI address width.
- TIMEOUT, 1024, wait cycles before timeout_err is set; 0 disables the watchdog.

Ports:
- clk_control  in  1  control clock; single clock for the whole block.
- clk_control_rst_high  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR  register address.
- cmd_wdata  in  BW  write data.
- cmd_wstrb  in  BWB  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  BW  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP from the slave.
- control_M_AXI_AWADDR/AWVALID  out  AXI_ADDR/1;  control_M_AXI_AWREADY  in  1.
- control_M_AXI_WDATA/WSTRB/WVALID  out  BW/BWB/1;  control_M_AXI_WREADY  in  1.
- control_M_AXI_BRESP/BVALID  in  2/1;  control_M_AXI_BREADY  out  1.
- control_M_AXI_ARADDR/ARVALID  out  AXI_ADDR/1;  control_M_AXI_ARREADY  in  1.
- control_M_AXI_RDATA/RRESP/RVALID  in  BW/2/1;  control_M_AXI_RREADY  out  1.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset: every output register is 0, state = IDLE, watchdog counter = 0. cmd_ready is combinational (state == IDLE), so it reads 1 after reset.
- Reset mid-transaction aborts immediately: all VALID/READY outputs drop in the next cycle. No drain of the slave is attempted.
- All AXI outputs and rsp_* are registered. AW/W/AR payload is captured at command accept and held stable while VALID is high.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, RSP.
- IDLE: on cmd_valid, latch the command. A write goes to WR with AWVALID=WVALID=1 next cycle. A read goes to RD with ARVALID=1.
- WR: AWVALID and WVALID are independent. Each clears in the cycle after its own handshake (VALID & READY). When both are done, or complete in the same cycle, go to WR_RESP with BREADY=1. No VALID waits on any READY.
- WR_RESP: on BVALID, capture BRESP, drop BREADY, go to RSP with rsp_valid=1, rsp_write=1, rsp_rdata=0.
- RD: on ARREADY, drop ARVALID, go to RD_DATA with RREADY=1.
- RD_DATA: on RVALID, capture RDATA/RRESP, drop RREADY, go to RSP.
- RSP: hold rsp_* stable until rsp_ready, then go to IDLE and drop rsp_valid.
- Latency, zero-wait slave, write: accept at cycle 0, AW/W handshake cycle 1, BVALID cycle 2, rsp_valid cycle 3.
- Latency, zero-wait slave, read: accept at cycle 0, AR cycle 1, RVALID cycle 2, rsp_valid cycle 3.
- Next cmd_ready is the cycle after the rsp handshake, so peak rate is one command per 4 cycles.
- Unexpected BVALID/RVALID outside WR_RESP/RD_DATA is ignored; READY stays low.
- Watchdog:
  - Counter increments each cycle in WR, WR_RESP, RD or RD_DATA, and clears on entry to RSP or IDLE.
  - Counter saturates at TIMEOUT.
  - Reaching TIMEOUT sets timeout_err. It is sticky, cleared only by reset.
  - The transaction keeps waiting; AXI-Lite has no abort.
- Response codes pass through unmodified; SLVERR/DECERR are not treated as errors internally.

Test Plan:
- Zero-wait write, addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, slave BRESP=0 -> AW/W valid cycle 1, BREADY cycle 2, rsp_valid cycle 3 with rsp_write=1, rsp_resp=0, rsp_rdata=0.
- Skewed write: WREADY 3 cycles before AWREADY -> WVALID drops after its handshake, AWVALID stays; data/addr stable; single B accepted; no duplicate W beat.
- Read addr 0x04, slave ARREADY after 2 cycles, RDATA=0x12345678, RRESP=2 -> rsp_rdata=0x12345678, rsp_resp=2, rsp_write=0.
- Back-pressure: rsp_ready low for 5 cycles -> rsp_* stable; cmd_ready=0 with cmd_valid held; next command accepted the cycle after the rsp handshake.
- Watchdog, TIMEOUT=16, slave never asserts BVALID -> timeout_err=1 at 16 wait cycles, busy stays 1. Late BVALID -> normal rsp; timeout_err remains 1.
- Reset asserted in RD_DATA -> next cycle ARVALID=RREADY=rsp_valid=0, busy=0, cmd_ready=1, timeout_err=0.
